toggle_activity_monitor: RTL and testbench
==========================================

Name: toggle_activity_monitor

Overview:
- Hardware consumer of switching activity. The stimulus benches drive a DUT and dump a VCD. This block works from the other end: it samples a bus of monitored DUT nets every clock and counts 0->1 and 1->0 transitions per bit over a fixed window of enabled cycles.
- At each window end it snapshots the per-bit toggle counts and streams them out one bit-index per valid/ready beat to the power-estimation datapath.

Parameters:
- WIDTH, 4, number of monitored nets (>=2).
- CNT_W, 8, per-bit toggle counter width; counters saturate.
- WINDOW, 8, enabled cycles per measurement window (>=2).
- IDX_W, $clog2(WIDTH), width of out_idx (derived).

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.
- en  in  1  sample enable; cycles with en=0 are not counted and do not advance the window.
- sig_in  in  WIDTH  monitored nets, sampled on rising clk.
- ovf_clr  in  1  single-cycle pulse; clears overflow.
- out_valid  out  1  result beat valid.
- out_ready  in  1  downstream accept.
- out_idx  out  IDX_W  bit index of the current beat.
- out_count  out  CNT_W  toggle count for bit out_idx.
- out_last  out  1  high on beat with out_idx==WIDTH-1.
- overflow  out  1  sticky; a snapshot was dropped because draining was still in progress.

Behaviour:
- Reset (async, rst_n=0): out_valid=0, out_idx=0, out_count=0, out_last=0, overflow=0. Live counters, shadow registers, window counter (wcnt) and prev_valid are all cleared. Drain FSM goes to D_IDLE. Asserting reset mid-drain abandons the drain.
- Sampling, per enabled cycle:
  - prev <= sig_in; prev_valid <= 1.
  - toggle = (sig_in ^ prev) & {WIDTH{prev_valid}}.
  - For each set toggle bit, live[i] increments, saturating at 2^CNT_W-1.
- en=0 cycle: live counters and wcnt hold, prev_valid <= 0. The first enabled cycle after a gap, or after reset, never counts a toggle.
- Window counting: wcnt increments on each enabled cycle.
- Window end, the enabled cycle with wcnt==WINDOW-1:
  - wcnt <= 0.
  - Snapshot value = live[i] + toggle[i] (this cycle's toggle included, saturating).
  - live[i] <= 0 for the next window.
  - If the FSM is in D_IDLE: shadow <= snapshot and FSM -> D_SEND.
  - Otherwise: the snapshot is discarded and overflow <= 1. Live counters are still cleared.
- Drain FSM:
  - D_IDLE: out_valid=0.
  - D_SEND: out_valid=1, out_count=shadow[out_idx], out_last=(out_idx==WIDTH-1).
    - Beat accepted when out_valid&&out_ready.
    - On an accepted beat that is not last: out_idx+1.
    - On an accepted last beat: out_idx <= 0, FSM -> D_IDLE.
  - First beat is visible the cycle after the window-end edge (latency 1).
  - out_idx, out_count and out_last are held stable while out_valid=1 and out_ready=0.
- Simultaneous window end and last-beat acceptance in the same cycle: counts as D_IDLE. The new snapshot is loaded, the FSM stays in D_SEND with out_idx=0, and no overflow is raised.
- Overflow priority: ovf_clr clears overflow, but a set in the same cycle wins.
- Counting continues unaffected while draining.

Test Plan:
- Pattern window, WIDTH=4, WINDOW=8, en=1 from reset release. Eight cycles of sig_in: bit0 alternates 0,1,0,1..., bit1=0, bit2 = 0,0,1,1,0,0,1,1, bit3 = 1,1,1,1,1,1,1,0. With out_ready=1 -> beats idx0..3 with counts 7,0,3,1; out_last on idx3; out_valid rises exactly one cycle after the 8th sample.
- Backpressure: hold out_ready=0 for 5 cycles on beat idx1 -> out_idx=1 and out_count held constant, then the drain resumes with no lost or duplicated beat.
- Overflow: keep out_ready=0 across a second window end -> overflow=1, the first window's counts are still delivered intact, and no second drain occurs. An ovf_clr pulse -> overflow=0.
- Enable gap: toggle bit0 every cycle; en=0 for 3 cycles mid-window while bit0 keeps toggling -> gap cycles are not counted, the first cycle after the gap is not counted, and the window closes after 8 enabled cycles.
- Saturation: CNT_W=2, bit0 toggling every cycle for a full window -> bit0 count reads 3.
- Reset mid-drain: assert rst_n=0 during beat idx2 -> all outputs go to 0 asynchronously. After release, the next window counts from zero with prev_valid=0.

Source files
------------

// File: rtl/toggle_activity_monitor.sv
// Counts per-bit 0->1/1->0 transitions of sig_in over WINDOW enabled cycles, then drains the snapshot one index per beat.
// First beat appears one cycle after the window-end edge; beats hold while out_ready=0, and a window closing mid-drain is dropped and flagged.

module toggle_activity_monitor #(
   parameter int WIDTH  = 4,
   parameter int CNT_W  = 8,
   parameter int WINDOW = 8,
   parameter int IDX_W  = $clog2(WIDTH)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             en,
   input  logic [WIDTH-1:0] sig_in,
   input  logic             ovf_clr,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [IDX_W-1:0] out_idx,
   output logic [CNT_W-1:0] out_count,
   output logic             out_last,
   output logic             overflow
);

   localparam int                WCNT_W    = $clog2(WINDOW);
   localparam logic [CNT_W-1:0]  CNT_MAX   = '1;
   localparam logic [WCNT_W-1:0] WCNT_LAST = WCNT_W'(WINDOW - 1);
   localparam logic [IDX_W-1:0]  IDX_LAST  = IDX_W'(WIDTH - 1);

   typedef enum logic {D_IDLE, D_SEND} drain_state_e;

   drain_state_e                  state_q, state_d;
   logic [WIDTH-1:0]              prev_q, prev_d;
   logic                          prev_valid_q, prev_valid_d;
   logic [WCNT_W-1:0]             wcnt_q, wcnt_d;
   logic [WIDTH-1:0][CNT_W-1:0]   live_q, live_d;
   logic [WIDTH-1:0][CNT_W-1:0]   shadow_q, shadow_d;
   logic [IDX_W-1:0]              idx_q, idx_d;
   logic                          overflow_q, overflow_d;

   logic [WIDTH-1:0]              toggle;
   logic [WIDTH-1:0][CNT_W-1:0]   live_inc;
   logic                          win_end;
   logic                          beat_acc;
   logic                          last_acc;
   logic                          drain_free;

   // live_inc doubles as the snapshot value: it already folds in this cycle's toggle.
   always_comb begin
      toggle = (sig_in ^ prev_q) & {WIDTH{prev_valid_q}};
      for (int i = 0; i < WIDTH; i++) begin
         if (toggle[i] && (live_q[i] != CNT_MAX)) begin
            live_inc[i] = live_q[i] + CNT_W'(1);
         end else begin
            live_inc[i] = live_q[i];
         end
      end
   end

   assign win_end    = en && (wcnt_q == WCNT_LAST);
   assign beat_acc   = (state_q == D_SEND) && out_ready;
   assign last_acc   = beat_acc && (idx_q == IDX_LAST);
   // A drain finishing on the window-end edge frees the shadow for the new snapshot.
   assign drain_free = (state_q == D_IDLE) || last_acc;

   always_comb begin
      prev_d       = prev_q;
      prev_valid_d = en;
      wcnt_d       = wcnt_q;
      live_d       = live_q;
      shadow_d     = shadow_q;
      overflow_d   = overflow_q;

      if (en) begin
         prev_d = sig_in;
         if (win_end) begin
            wcnt_d = '0;
            live_d = '0;
         end else begin
            wcnt_d = wcnt_q + WCNT_W'(1);
            live_d = live_inc;
         end
      end

      if (win_end && drain_free) begin
         shadow_d = live_inc;
      end

      if (win_end && !drain_free) begin
         overflow_d = 1'b1;
      end else if (ovf_clr) begin
         overflow_d = 1'b0;
      end
   end

   always_comb begin
      state_d = state_q;
      idx_d   = idx_q;
      case (state_q)
         D_IDLE: begin
            if (win_end) begin
               state_d = D_SEND;
               idx_d   = '0;
            end
         end
         D_SEND: begin
            if (beat_acc) begin
               if (idx_q == IDX_LAST) begin
                  idx_d   = '0;
                  state_d = win_end ? D_SEND : D_IDLE;
               end else begin
                  idx_d = idx_q + IDX_W'(1);
               end
            end
         end
         default: begin
            state_d = D_IDLE;
            idx_d   = '0;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= D_IDLE;
         prev_q       <= '0;
         prev_valid_q <= 1'b0;
         wcnt_q       <= '0;
         live_q       <= '0;
         shadow_q     <= '0;
         idx_q        <= '0;
         overflow_q   <= 1'b0;
      end else begin
         state_q      <= state_d;
         prev_q       <= prev_d;
         prev_valid_q <= prev_valid_d;
         wcnt_q       <= wcnt_d;
         live_q       <= live_d;
         shadow_q     <= shadow_d;
         idx_q        <= idx_d;
         overflow_q   <= overflow_d;
      end
   end

   assign out_valid = (state_q == D_SEND);
   assign out_idx   = idx_q;
   assign out_count = shadow_q[idx_q];
   assign out_last  = out_valid && (idx_q == IDX_LAST);
   assign overflow  = overflow_q;

endmodule

// File: tb/tb_toggle_activity_monitor.sv
// Directed bench: main instance (CNT_W=8) plus a CNT_W=2 twin on the same inputs for saturation.
module tb_toggle_activity_monitor;

   logic       clk;
   logic       rst_n;
   logic       en;
   logic [3:0] sig_in;
   logic       ovf_clr;
   logic       out_ready;

   logic       out_valid;
   logic [1:0] out_idx;
   logic [7:0] out_count;
   logic       out_last;
   logic       overflow;

   logic       out_valid_s;
   logic [1:0] out_idx_s;
   logic [1:0] out_count_s;
   logic       out_last_s;
   logic       overflow_s;

   int n_cmp = 0;
   int n_err = 0;

   toggle_activity_monitor #(.WIDTH(4), .CNT_W(8), .WINDOW(8)) dut (
      .clk(clk), .rst_n(rst_n), .en(en), .sig_in(sig_in), .ovf_clr(ovf_clr),
      .out_valid(out_valid), .out_ready(out_ready), .out_idx(out_idx),
      .out_count(out_count), .out_last(out_last), .overflow(overflow)
   );

   toggle_activity_monitor #(.WIDTH(4), .CNT_W(2), .WINDOW(8)) dut_sat (
      .clk(clk), .rst_n(rst_n), .en(en), .sig_in(sig_in), .ovf_clr(ovf_clr),
      .out_valid(out_valid_s), .out_ready(out_ready), .out_idx(out_idx_s),
      .out_count(out_count_s), .out_last(out_last_s), .overflow(overflow_s)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   // sel 0: test-plan pattern (counts 7,0,3,1); sel 1: binary count k (counts 7,3,1,0).
   function automatic logic [3:0] vec(input int sel, input int k);
      logic [3:0] v;
      if (sel == 1) begin
         v = 4'(k);
      end else begin
         case (k)
            0:       v = 4'b1000;
            1:       v = 4'b1001;
            2:       v = 4'b1100;
            3:       v = 4'b1101;
            4:       v = 4'b1000;
            5:       v = 4'b1001;
            6:       v = 4'b1100;
            default: v = 4'b0101;
         endcase
      end
      return v;
   endfunction

   // Eight enabled samples; returns at the negedge just after the window-end edge, en still 1.
   task automatic run_window(input string tag, input int sel, input bit chk_pre);
      for (int k = 0; k < 8; k++) begin
         if (k == 7 && chk_pre) chk({tag, "_valid_before_end"}, out_valid, 0);
         en     = 1'b1;
         sig_in = vec(sel, k);
         @(negedge clk);
      end
   endtask

   // Expects beat idx0 visible now and out_ready=1; walks all four beats then idle.
   task automatic drain4(input string tag, input logic [31:0] exp, input logic [7:0] exps);
      for (int i = 0; i < 4; i++) begin
         chk($sformatf("%s_valid%0d", tag, i), out_valid, 1);
         chk($sformatf("%s_idx%0d", tag, i), out_idx, i);
         chk($sformatf("%s_cnt%0d", tag, i), out_count, exp[i*8 +: 8]);
         chk($sformatf("%s_last%0d", tag, i), out_last, (i == 3) ? 1 : 0);
         chk($sformatf("%s_satcnt%0d", tag, i), out_count_s, exps[i*2 +: 2]);
         @(negedge clk);
      end
      chk({tag, "_idle"}, out_valid, 0);
      chk({tag, "_idle_idx"}, out_idx, 0);
   endtask

   initial begin
      rst_n     = 1'b0;
      en        = 1'b0;
      sig_in    = 4'b0000;
      ovf_clr   = 1'b0;
      out_ready = 1'b1;
      repeat (2) @(negedge clk);

      chk("rst_valid", out_valid, 0);
      chk("rst_idx", out_idx, 0);
      chk("rst_count", out_count, 0);
      chk("rst_last", out_last, 0);
      chk("rst_ovf", overflow, 0);

      // Pattern window from reset release.
      rst_n = 1'b1;
      run_window("pat", 0, 1'b1);
      en = 1'b0;
      drain4("pat", {8'd1, 8'd3, 8'd0, 8'd7}, {2'd1, 2'd3, 2'd0, 2'd3});

      // Backpressure on beat idx1.
      run_window("bp", 1, 1'b1);
      en = 1'b0;
      chk("bp_idx0", out_idx, 0);
      chk("bp_cnt0", out_count, 7);
      @(negedge clk);
      out_ready = 1'b0;
      for (int i = 0; i < 5; i++) begin
         chk("bp_hold_valid", out_valid, 1);
         chk("bp_hold_idx", out_idx, 1);
         chk("bp_hold_cnt", out_count, 3);
         chk("bp_hold_last", out_last, 0);
         @(negedge clk);
      end
      out_ready = 1'b1;
      chk("bp_resume_idx", out_idx, 1);
      chk("bp_resume_cnt", out_count, 3);
      @(negedge clk);
      chk("bp_idx2", out_idx, 2);
      chk("bp_cnt2", out_count, 1);
      @(negedge clk);
      chk("bp_idx3", out_idx, 3);
      chk("bp_cnt3", out_count, 0);
      chk("bp_last3", out_last, 1);
      @(negedge clk);
      chk("bp_idle", out_valid, 0);

      // Overflow: second window closes while the first is stalled.
      out_ready = 1'b0;
      run_window("ovA", 0, 1'b1);
      chk("ov_first_valid", out_valid, 1);
      chk("ov_first_ovf", overflow, 0);
      run_window("ovB", 1, 1'b0);
      en = 1'b0;
      chk("ov_set", overflow, 1);
      chk("ov_sat_set", overflow_s, 1);
      out_ready = 1'b1;
      drain4("ov", {8'd1, 8'd3, 8'd0, 8'd7}, {2'd1, 2'd3, 2'd0, 2'd3});
      @(negedge clk);
      chk("ov_no_second_drain", out_valid, 0);
      chk("ov_sticky", overflow, 1);
      ovf_clr = 1'b1;
      @(negedge clk);
      ovf_clr = 1'b0;
      chk("ov_cleared", overflow, 0);

      // Enable gap: bit0 toggles every cycle, en low for 3 cycles.
      sig_in = 4'b0000;
      for (int i = 0; i < 11; i++) begin
         if (i == 10) chk("gap_valid_before_end", out_valid, 0);
         en     = !(i >= 4 && i <= 6);
         sig_in = {3'b000, ~sig_in[0]};
         @(negedge clk);
      end
      en = 1'b0;
      drain4("gap", {8'd0, 8'd0, 8'd0, 8'd6}, {2'd0, 2'd0, 2'd0, 2'd3});

      // Reset mid-drain while counting continues on bit3.
      run_window("rd", 0, 1'b1);
      chk("rd_cnt0", out_count, 7);
      sig_in = 4'b1101;
      @(negedge clk);
      chk("rd_idx1", out_idx, 1);
      sig_in = 4'b0101;
      @(negedge clk);
      chk("rd_idx2", out_idx, 2);
      chk("rd_cnt2", out_count, 3);
      rst_n = 1'b0;
      en    = 1'b0;
      #1;
      chk("rd_async_valid", out_valid, 0);
      chk("rd_async_idx", out_idx, 0);
      chk("rd_async_count", out_count, 0);
      chk("rd_async_last", out_last, 0);
      chk("rd_async_ovf", overflow, 0);
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      run_window("post", 1, 1'b1);
      en = 1'b0;
      drain4("post", {8'd0, 8'd1, 8'd3, 8'd7}, {2'd0, 2'd1, 2'd3, 2'd3});

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
